// File: rtl/sincos_pkg.sv
// Shared types and constants for the iterative CORDIC sin/cos unit.
// SINCOS_FLOAT_OUT_EN selects IEEE-754 single outputs and adds the CONV state.
package sincos_pkg;

`ifdef SINCOS_FLOAT_OUT_EN
    localparam bit FLOAT_OUT = 1'b1;
    typedef enum logic [1:0] {S_IDLE, S_ROT, S_FIX, S_CONV} state_t;
`else
    localparam bit FLOAT_OUT = 1'b0;
    typedef enum logic [1:0] {S_IDLE, S_ROT, S_FIX} state_t;
`endif

    // Aggregate CORDIC gain compensation, 0.6072529350 in Q1.30.
    localparam logic [31:0] CORDIC_K = 32'h26DD_3B6A;

    // atan(2^-i) in turns scaled by 2^32; MSB-aligned with the phase word.
    localparam logic [31:0] ATAN_TBL [0:29] = '{
        32'h2000_0000, 32'h12E4_051D, 32'h09FB_385B, 32'h0511_11D4,
        32'h028B_0D43, 32'h0145_D7E1, 32'h00A2_F61E, 32'h0051_7C55,
        32'h0028_BE53, 32'h0014_5F2E, 32'h000A_2F98, 32'h0005_17CC,
        32'h0002_8BE6, 32'h0001_45F3, 32'h0000_A2F9, 32'h0000_517C,
        32'h0000_28BE, 32'h0000_145F, 32'h0000_0A2F, 32'h0000_0517,
        32'h0000_028B, 32'h0000_0145, 32'h0000_00A2, 32'h0000_0051,
        32'h0000_0028, 32'h0000_0014, 32'h0000_000A, 32'h0000_0005,
        32'h0000_0002, 32'h0000_0001
    };

    localparam int FP_BIAS   = 127;
    localparam int FP_EXP_W  = 8;
    localparam int FP_MANT_W = 23;

endpackage

// File: rtl/fx_to_fp32.sv
// Combinational Q1.(WIDTH-2) signed fixed point to IEEE-754 single converter.
// Mantissa is truncated; only instanced when SINCOS_FLOAT_OUT_EN is defined.
module fx_to_fp32
    import sincos_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] fx,
    output logic [31:0]      fp
);
    logic                sign;
    logic [WIDTH-1:0]    mag;
    logic [5:0]          msb;
    logic [63:0]         norm;
    logic [FP_EXP_W-1:0] expo;

    // NOTE: every always_comb output is assigned a default first so no latch is inferred.
    always_comb begin
        sign = fx[WIDTH-1];
        mag  = sign ? (~fx + 1'b1) : fx;
        msb  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (mag[i]) msb = 6'(i);
        end
        // Leading one lands on bit 63; the next 23 bits are the mantissa.
        norm = {mag, {(64 - WIDTH){1'b0}}} << (6'(WIDTH - 1) - msb);
        expo = FP_EXP_W'(FP_BIAS + int'(msb) - (WIDTH - 2));
        fp   = (mag == '0) ? '0 : {sign, expo, norm[62 -: FP_MANT_W]};
    end

endmodule

// File: rtl/cordic_sincos.sv
// Iterative CORDIC sine/cosine: one micro-rotation per cycle, quadrant fold at the end.
// Define SINCOS_FLOAT_OUT_EN for IEEE-754 single outputs (extra CONV cycle).
module cordic_sincos
    import sincos_pkg::*;
#(
    parameter  int WIDTH = 32,
    parameter  int ITER  = 24,
    parameter  int GUARD = 2,
    localparam int RES_W = FLOAT_OUT ? 32 : WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] phase,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [RES_W-1:0] sine_result,
    output logic [RES_W-1:0] cosine_result
);
    localparam int IW = WIDTH + GUARD;
    typedef logic signed [IW-1:0] dp_t;
    localparam dp_t DP_MIN = {1'b1, {(IW - 1){1'b0}}};
    localparam dp_t DP_MAX = {1'b0, {(IW - 1){1'b1}}};

    function automatic dp_t align32(input logic [31:0] v);
        logic [63:0] t;
        t = {v, 32'd0};
        return dp_t'(t[63 -: IW]);
    endfunction

    function automatic dp_t neg_sat(input dp_t v);
        return (v == DP_MIN) ? DP_MAX : -v;
    endfunction

    // Drop the guard LSBs with round-half-up (add half an output LSB, then shift).
    function automatic logic [WIDTH-1:0] round_drop(input dp_t v);
        logic signed [IW:0] t;
        t = $signed({v[IW-1], v}) + $signed((IW + 1)'((1 << GUARD) >> 1));
        t = t >>> GUARD;
        return t[WIDTH-1:0];
    endfunction

    state_t     state;
    logic [1:0] quad;
    logic [4:0] cnt;
    dp_t        x, y, z;
    dp_t        x_nxt, y_nxt, z_nxt, atan_i;
    dp_t        sin_fold, cos_fold;
    logic       dir_pos;

    always_comb begin
        dir_pos = ~z[IW-1];
        atan_i  = align32(ATAN_TBL[cnt]);
        x_nxt   = dir_pos ? x - (y >>> cnt) : x + (y >>> cnt);
        y_nxt   = dir_pos ? y + (x >>> cnt) : y - (x >>> cnt);
        z_nxt   = dir_pos ? z - atan_i : z + atan_i;
    end

    always_comb begin
        cos_fold = x;
        sin_fold = y;
        case (quad)
            2'd1:    begin cos_fold = neg_sat(y); sin_fold = x;          end
            2'd2:    begin cos_fold = neg_sat(x); sin_fold = neg_sat(y); end
            2'd3:    begin cos_fold = y;          sin_fold = neg_sat(x); end
            default: begin cos_fold = x;          sin_fold = y;          end
        endcase
    end

`ifdef SINCOS_FLOAT_OUT_EN
    logic [WIDTH-1:0] sin_fx, cos_fx;
    logic [31:0]      sin_fp, cos_fp;

    fx_to_fp32 #(.WIDTH(WIDTH)) u_sin_fp (.fx(sin_fx), .fp(sin_fp));
    fx_to_fp32 #(.WIDTH(WIDTH)) u_cos_fp (.fx(cos_fx), .fp(cos_fp));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            ready         <= 1'b1;
            busy          <= 1'b0;
            done          <= 1'b0;
            sine_result   <= '0;
            cosine_result <= '0;
            cnt           <= '0;
            quad          <= '0;
            // NOTE: datapath registers are reset too so an aborted run leaves no stale X/Y/Z.
            x             <= '0;
            y             <= '0;
            z             <= '0;
`ifdef SINCOS_FLOAT_OUT_EN
            sin_fx        <= '0;
            cos_fx        <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        quad  <= phase[WIDTH-1 -: 2];
                        z     <= dp_t'({2'b00, phase[WIDTH-3:0]}) << GUARD;
                        x     <= align32(CORDIC_K);
                        y     <= '0;
                        cnt   <= '0;
                        state <= S_ROT;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                S_ROT: begin
                    x   <= x_nxt;
                    y   <= y_nxt;
                    z   <= z_nxt;
                    cnt <= cnt + 5'd1;
                    if (cnt == 5'(ITER - 1)) state <= S_FIX;
                end
`ifdef SINCOS_FLOAT_OUT_EN
                S_FIX: begin
                    sin_fx <= round_drop(sin_fold);
                    cos_fx <= round_drop(cos_fold);
                    state  <= S_CONV;
                end
                S_CONV: begin
                    sine_result   <= sin_fp;
                    cosine_result <= cos_fp;
                    done          <= 1'b1;
                    ready         <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
`else
                S_FIX: begin
                    sine_result   <= round_drop(sin_fold);
                    cosine_result <= round_drop(cos_fold);
                    done          <= 1'b1;
                    ready         <= 1'b1;
                    busy          <= 1'b0;
                    state         <= S_IDLE;
                end
`endif
                default: begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cordic_sincos.sv
// Directed bench for cordic_sincos (WIDTH=32, ITER=24); follows SINCOS_FLOAT_OUT_EN.
module tb_cordic_sincos;
    localparam int ITER = 24;

`ifdef SINCOS_FLOAT_OUT_EN
    localparam int          LAT    = ITER + 3;
    localparam int          TOL    = 4;
    localparam logic [31:0] V_ONE  = 32'h3F80_0000;
    localparam logic [31:0] V_MONE = 32'hBF80_0000;
    localparam logic [31:0] V_R2   = 32'h3F35_04F3;
`else
    localparam int          LAT    = ITER + 2;
    localparam int          TOL    = 128;
    localparam logic [31:0] V_ONE  = 32'h4000_0000;
    localparam logic [31:0] V_MONE = 32'hC000_0000;
    localparam logic [31:0] V_R2   = 32'h2D41_3CCD;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] phase;
    logic        ready, busy, done;
    logic [31:0] sine_result, cosine_result;

    int tests = 0;
    int fails = 0;

    cordic_sincos #(.WIDTH(32), .ITER(ITER), .GUARD(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .phase         (phase),
        .ready         (ready),
        .busy          (busy),
        .done          (done),
        .sine_result   (sine_result),
        .cosine_result (cosine_result)
    );

    always #5 clk = ~clk;

    function automatic int absdiff(input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] d;
        if ($isunknown(a)) return 32'h7FFF_FFFF;
        d = a - b;
        return (d < 0) ? -int'(d) : int'(d);
    endfunction

    task automatic start_op(input logic [31:0] ph);
        @(negedge clk);
        phase = ph;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Returns the number of edges after the start edge until done is seen, -1 on timeout.
    task automatic wait_done(output int n);
        n = -1;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            #1;
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst   = 1'b1;
        start = 1'b0;
        phase = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL reset_ready: got %b want 1", ready); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done: got %b want 0", done); end
        tests++; if (sine_result !== 32'h0) begin fails++; $display("FAIL reset_sin: got %h want 0", sine_result); end
        tests++; if (cosine_result !== 32'h0) begin fails++; $display("FAIL reset_cos: got %h want 0", cosine_result); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_zero_phase;
        int n;
        start_op(32'h0000_0000);
        wait_done(n);
        tests++; if (n + 1 !== LAT) begin fails++; $display("FAIL zero_latency: got %0d cycles want %0d", n + 1, LAT); end
        tests++; if (absdiff(cosine_result, V_ONE) > TOL) begin fails++; $display("FAIL zero_cos: got %h want %h", cosine_result, V_ONE); end
`ifndef SINCOS_FLOAT_OUT_EN
        tests++; if (absdiff(sine_result, 32'h0) > TOL) begin fails++; $display("FAIL zero_sin: got %h want 0", sine_result); end
`endif
        @(posedge clk);
        #1;
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL done_pulse_width: got %b want 0", done); end
    endtask

    task automatic test_45deg;
        int n;
        start_op(32'h2000_0000);
        wait_done(n);
        tests++; if (n + 1 !== LAT) begin fails++; $display("FAIL d45_latency: got %0d want %0d", n + 1, LAT); end
        tests++; if (absdiff(sine_result, V_R2) > TOL) begin fails++; $display("FAIL d45_sin: got %h want %h", sine_result, V_R2); end
        tests++; if (absdiff(cosine_result, V_R2) > TOL) begin fails++; $display("FAIL d45_cos: got %h want %h", cosine_result, V_R2); end
    endtask

    task automatic test_back_to_back;
        int n;
        start_op(32'h4000_0000);
        wait_done(n);
        tests++; if (n + 1 !== LAT) begin fails++; $display("FAIL b2b_latency1: got %0d want %0d", n + 1, LAT); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_on_done: got %b want 1", ready); end
        tests++; if (absdiff(sine_result, V_ONE) > TOL) begin fails++; $display("FAIL b2b_sin1: got %h want %h", sine_result, V_ONE); end
`ifndef SINCOS_FLOAT_OUT_EN
        tests++; if (absdiff(cosine_result, 32'h0) > TOL) begin fails++; $display("FAIL b2b_cos1: got %h want 0", cosine_result); end
`endif
        // Second request issued in the done cycle itself.
        phase = 32'hC000_0000;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(n);
        tests++; if (n + 1 !== LAT) begin fails++; $display("FAIL b2b_done_spacing: got %0d want %0d", n + 1, LAT); end
        tests++; if (absdiff(sine_result, V_MONE) > TOL) begin fails++; $display("FAIL b2b_sin2: got %h want %h", sine_result, V_MONE); end
`ifndef SINCOS_FLOAT_OUT_EN
        tests++; if (absdiff(cosine_result, 32'h0) > TOL) begin fails++; $display("FAIL b2b_cos2: got %h want 0", cosine_result); end
`endif
    endtask

    task automatic test_start_while_busy;
        int dones    = 0;
        int ready_hi = 0;
        start_op(32'h4000_0000);
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
            if (busy === 1'b1) begin
                if (ready !== 1'b0) ready_hi++;
                start = 1'b1;
                phase = 32'h8000_0000 + 32'(i) * 32'h0123_4567;
            end else begin
                start = 1'b0;
            end
        end
        start = 1'b0;
        tests++; if (dones !== 1) begin fails++; $display("FAIL busy_single_done: got %0d want 1", dones); end
        tests++; if (ready_hi !== 0) begin fails++; $display("FAIL busy_ready_low: got %0d high cycles want 0", ready_hi); end
        tests++; if (absdiff(sine_result, V_ONE) > TOL) begin fails++; $display("FAIL busy_sin: got %h want %h", sine_result, V_ONE); end
`ifndef SINCOS_FLOAT_OUT_EN
        tests++; if (absdiff(cosine_result, 32'h0) > TOL) begin fails++; $display("FAIL busy_cos: got %h want 0", cosine_result); end
`endif
    endtask

    task automatic test_abort;
        int n;
        int dones = 0;
        start_op(32'h8000_0000);
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL abort_busy: got %b want 0", busy); end
        tests++; if (ready !== 1'b1) begin fails++; $display("FAIL abort_ready: got %b want 1", ready); end
        tests++; if (done !== 1'b0) begin fails++; $display("FAIL abort_done: got %b want 0", done); end
        tests++; if (sine_result !== 32'h0) begin fails++; $display("FAIL abort_sin: got %h want 0", sine_result); end
        tests++; if (cosine_result !== 32'h0) begin fails++; $display("FAIL abort_cos: got %h want 0", cosine_result); end
        rst = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        tests++; if (dones !== 0) begin fails++; $display("FAIL abort_no_done: got %0d want 0", dones); end
        start_op(32'h8000_0000);
        wait_done(n);
        tests++; if (n + 1 !== LAT) begin fails++; $display("FAIL abort_restart_latency: got %0d want %0d", n + 1, LAT); end
        tests++; if (absdiff(cosine_result, V_MONE) > TOL) begin fails++; $display("FAIL abort_restart_cos: got %h want %h", cosine_result, V_MONE); end
`ifndef SINCOS_FLOAT_OUT_EN
        tests++; if (absdiff(sine_result, 32'h0) > TOL) begin fails++; $display("FAIL abort_restart_sin: got %h want 0", sine_result); end
`endif
    endtask

    initial begin
        test_reset();
        test_zero_phase();
        test_45deg();
        test_back_to_back();
        test_start_while_busy();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
